strobe_sample_source: RTL and testbench

//  Strobed sample transmitter feeding the moving-average datapath: emits a finite train
//  of DATA_W-bit samples, one single-cycle strobe per sample, at a programmable spacing.

---
 rtl/strobe_sample_source.sv | 179 +++++++++++++++++
 tb/tb_strobe_sample_source.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/strobe_sample_source.sv
// Strobed test-pattern source: emits a finite train of samples (impulse, step, ramp
// or square), one single-cycle strobe per sample, at a programmable strobe spacing.
module strobe_sample_source #(
    parameter int DATA_W = 10,
    parameter int DIV_W  = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] amplitude,
    input  logic [DIV_W-1:0]  interval,
    input  logic [LEN_W-1:0]  length,
    input  logic [LEN_W-1:0]  position,
    output logic [DATA_W-1:0] data_out,
    output logic              strobe_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [DATA_W-1:0]   amp_q, amp_d;
    logic [DIV_W-1:0]    ivl_q, ivl_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    pos_q, pos_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [DIV_W-1:0]    wait_q, wait_d;
    logic [DATA_W-1:0]   ramp_q, ramp_d;
    logic [LEN_W-1:0]    sq_cnt_q, sq_cnt_d;
    logic                sq_hi_q, sq_hi_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                strobe_q, strobe_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DATA_W:0]     ramp_sum;
    logic [LEN_W-1:0]    sq_pm;
    logic [LEN_W-1:0]    in_pm;
    logic [DIV_W-1:0]    in_ivl;
    logic [DATA_W-1:0]   run_sample;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        amp_d    = amp_q;
        ivl_d    = ivl_q;
        len_d    = len_q;
        pos_d    = pos_q;
        idx_d    = idx_q;
        wait_d   = wait_q;
        ramp_d   = ramp_q;
        sq_cnt_d = sq_cnt_q;
        sq_hi_d  = sq_hi_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;

        ramp_sum = {1'b0, ramp_q} + {1'b0, amp_q};
        sq_pm    = (pos_q == '0) ? LEN_W'(1) : pos_q;
        in_pm    = (position == '0) ? LEN_W'(1) : position;
        in_ivl   = (interval < DIV_W'(2)) ? DIV_W'(2) : interval;

        // Generators (ramp_q, sq_cnt_q/sq_hi_q) always describe sample idx_q.
        case (mode_q)
            2'd0:    run_sample = (idx_q == pos_q) ? amp_q : '0;
            2'd1:    run_sample = (idx_q < pos_q) ? '0 : amp_q;
            2'd2:    run_sample = ramp_q;
            default: run_sample = sq_hi_q ? amp_q : '0;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    amp_d  = amplitude;
                    ivl_d  = in_ivl;
                    len_d  = length;
                    pos_d  = position;
                    if (length == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = RUN;
                        busy_d   = 1'b1;
                        strobe_d = 1'b1;
                        case (mode)
                            2'd2:    data_d = '0;
                            2'd3:    data_d = amplitude;
                            default: data_d = (position == '0) ? amplitude : '0;
                        endcase
                        idx_d    = LEN_W'(1);
                        wait_d   = in_ivl - DIV_W'(1);
                        ramp_d   = amplitude;
                        sq_cnt_d = (in_pm == LEN_W'(1)) ? '0 : LEN_W'(1);
                        sq_hi_d  = (in_pm != LEN_W'(1));
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    data_d  = '0;
                end else if (strobe_q && (idx_q == len_q)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    data_d  = '0;
                end else if (wait_q == '0) begin
                    strobe_d = 1'b1;
                    data_d   = run_sample;
                    idx_d    = idx_q + LEN_W'(1);
                    wait_d   = ivl_q - DIV_W'(1);
                    ramp_d   = ramp_sum[DATA_W] ? '1 : ramp_sum[DATA_W-1:0];
                    if (sq_cnt_q + LEN_W'(1) == sq_pm) begin
                        sq_cnt_d = '0;
                        sq_hi_d  = ~sq_hi_q;
                    end else begin
                        sq_cnt_d = sq_cnt_q + LEN_W'(1);
                    end
                end else begin
                    wait_d = wait_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            amp_q    <= '0;
            ivl_q    <= '0;
            len_q    <= '0;
            pos_q    <= '0;
            idx_q    <= '0;
            wait_q   <= '0;
            ramp_q   <= '0;
            sq_cnt_q <= '0;
            sq_hi_q  <= 1'b0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            amp_q    <= amp_d;
            ivl_q    <= ivl_d;
            len_q    <= len_d;
            pos_q    <= pos_d;
            idx_q    <= idx_d;
            wait_q   <= wait_d;
            ramp_q   <= ramp_d;
            sq_cnt_q <= sq_cnt_d;
            sq_hi_q  <= sq_hi_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign data_out   = data_q;
    assign strobe_out = strobe_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_strobe_sample_source.sv
// Scoreboard bench for strobe_sample_source: runs are predicted from the pattern rules
// into a queue; a negedge monitor pops and compares every strobe, busy and done.
module tb_strobe_sample_source;
    localparam int DW = 10;
    localparam int VW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    mode = '0;
    logic [DW-1:0] amplitude = '0;
    logic [VW-1:0] interval = '0;
    logic [LW-1:0] length = '0;
    logic [LW-1:0] position = '0;
    logic [DW-1:0] data_out;
    logic          strobe_out;
    logic          busy;
    logic          done;

    strobe_sample_source #(.DATA_W(DW), .DIV_W(VW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .amplitude(amplitude), .interval(interval), .length(length), .position(position),
        .data_out(data_out), .strobe_out(strobe_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // cyc == X at a negedge means "the cycle following rising edge number X".
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; int d; } exp_t;
    exp_t exp_q[$];
    int busy_lo = 1;
    int busy_hi = 0;
    int done_cyc = -1;
    int last_data = 0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    function automatic int sample(input int m, input int a, input int p, input int k);
        int pp;
        case (m)
            0: return (k == p) ? a : 0;
            1: return (k < p) ? 0 : a;
            2: return (k * a > 1023) ? 1023 : k * a;
            default: begin
                pp = (p < 1) ? 1 : p;
                return (((k / pp) % 2) == 0) ? a : 0;
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (cyc >= 1) begin
            automatic logic eb = (cyc >= busy_lo) && (cyc <= busy_hi);
            exp_t e;
            chk("busy", busy, eb);
            chk("done", done, (cyc == done_cyc));
            while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
                chk("strobe_missed_cyc", cyc, exp_q[0].c);
                void'(exp_q.pop_front());
            end
            if (strobe_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("strobe_spurious", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_cyc", cyc, e.c);
                    chk("strobe_data", data_out, e.d);
                    last_data = e.d;
                end
            end else begin
                chk("strobe_low", strobe_out, 0);
                chk("data_hold", data_out, eb ? last_data : 0);
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after a rising edge with the DUT idle.
    // kill_kind: 0 none, 1 abort, 2 reset; kill_off places the kill edge after the start edge.
    task automatic run(input int m, input int a, input int iv, input int l, input int p,
                       input int kill_kind, input int kill_off);
        int ie, n, slast, d, m_edge, end_edge;
        mode = 2'(m); amplitude = DW'(a); interval = VW'(iv); length = LW'(l);
        position = LW'(p); start = 1'b1;
        ie = (iv < 2) ? 2 : iv;
        n = cyc + 1;
        slast = n + (l - 1) * ie;
        d = (l == 0) ? n : slast + 1;
        m_edge = 0;
        if (kill_kind != 0 && l > 0) begin
            m_edge = n + 1 + kill_off;
            if (m_edge > d) m_edge = d;
        end
        for (int k = 0; k < l; k++) begin
            exp_t e;
            e.c = n + k * ie;
            e.d = sample(m, a, p, k);
            if (m_edge == 0 || e.c < m_edge) exp_q.push_back(e);
        end
        busy_lo = n;
        busy_hi = (m_edge != 0) ? m_edge - 1 : ((l == 0) ? n - 1 : slast);
        done_cyc = (m_edge != 0) ? -1 : d;
        end_edge = (m_edge != 0) ? m_edge : d + 1;
        for (int g = 0; g < 5000; g++) begin
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0; rst = 1'b0;
            if (cyc + 1 > end_edge + 1) break;
            mode = 2'($urandom); amplitude = DW'($urandom); interval = VW'($urandom);
            length = LW'($urandom); position = LW'($urandom);
            if (cyc + 1 <= end_edge && ($urandom % 4) == 0) start = 1'b1;
            if (cyc + 1 == m_edge) begin
                if (kill_kind == 1) abort = 1'b1;
                else rst = 1'b1;
            end
        end
        while (exp_q.size() > 0) begin
            chk("strobe_never_seen", 0, 1);
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got timeout expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run(0, 1023, 2, 50, 10, 0, 0);
        run(2, 300, 3, 5, 0, 0, 0);
        run(3, 512, 0, 8, 2, 0, 0);
        run(1, 400, 5, 0, 0, 0, 0);
        run(1, 700, 4, 10, 2, 1, 8);
        run(2, 900, 1, 12, 0, 1, 22);
        run(0, 55, 3, 9, 4, 2, 10);
        run(3, 77, 2, 7, 0, 0, 0);
        run(0, 5, 2, 6, 9, 0, 0);
        for (int t = 0; t < 30; t++) begin
            int m, a, iv, l, p, r, kk, ko;
            m = $urandom_range(0, 3);
            a = $urandom_range(0, 1023);
            iv = $urandom_range(0, 5);
            l = $urandom_range(0, 20);
            p = $urandom_range(0, l + 3);
            r = $urandom_range(0, 5);
            kk = (r == 1) ? 1 : ((r == 2) ? 2 : 0);
            ko = (l > 0) ? $urandom_range(0, (l - 1) * ((iv < 2) ? 2 : iv)) : 0;
            run(m, a, iv, l, p, kk, ko);
        end
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
